// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory-game sequence checker.
package memory_game_pkg;

  // Depth of the sequence register file; indices are 4 bits wide.
  localparam int MAX_SEQ_DEPTH = 16;

  // Game controller states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GEN      = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_INPUT    = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  // Larger of two integers, used to size the shared show/gap timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sequence_playback_checker_seq_store.sv
// 16x4 sequence register file: one synchronous write port, one
// combinational read port. Contents are deliberately not reset.
module seq_store
  import memory_game_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [3:0] wdata_i,
  input  logic [3:0] raddr_i,
  output logic [3:0] rdata_o
);

  logic [3:0] mem_q [MAX_SEQ_DEPTH];

  // Capture a new sequence digit when the controller appends one.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sequence_playback_checker.sv
// Memory-game controller: appends a digit per round, plays the sequence
// back on the display, then checks the player's entries against it.
module sequence_playback_checker
  import memory_game_pkg::*;
#(
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int MAX_LEN     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] random_num,
  input  logic       enable,
  input  logic       start,
  input  logic       user_valid,
  input  logic [3:0] user_digit,
  output logic [3:0] display_digit,
  output logic       display_on,
  output logic       prompt,
  output logic [4:0] level,
  output logic       win,
  output logic       lose
);

  localparam int TIMER_MAX = max_int(SHOW_CYCLES, GAP_CYCLES);
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);
  localparam logic [4:0] MAX_LEVEL = 5'(MAX_LEN);

  state_e             state_q, state_d;
  logic [4:0]         level_q, level_d;
  logic [3:0]         show_idx_q, show_idx_d;
  logic [3:0]         chk_idx_q, chk_idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic [3:0] disp_digit_q, disp_digit_d;
  logic       disp_on_q, disp_on_d;
  logic       prompt_q, prompt_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;

  logic       mem_we;
  logic [3:0] mem_raddr;
  logic [3:0] mem_rdata;
  logic [3:0] last_idx;

  // Index of the newest stored digit (level is at least 1 wherever used).
  assign last_idx = level_q[3:0] - 4'd1;

  // The single read port serves the checker in INPUT and the display otherwise.
  assign mem_raddr = (state_q == ST_INPUT) ? chk_idx_q : show_idx_d;

  seq_store u_seq_store (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (level_q[3:0]),
    .wdata_i (random_num),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // Next-state logic for the game controller, counters and memory write.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    show_idx_d = show_idx_q;
    chk_idx_d  = chk_idx_q;
    timer_d    = timer_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_GEN;
          level_d = 5'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GEN: begin
        if (enable) begin
          mem_we     = 1'b1;
          level_d    = level_q + 5'd1;
          show_idx_d = 4'd0;
          timer_d    = TIMER_ZERO;
          state_d    = ST_SHOW_ON;
        end else begin
          state_d = ST_GEN;
        end
      end
      ST_SHOW_ON: begin
        if (timer_q == SHOW_LAST) begin
          timer_d = TIMER_ZERO;
          state_d = ST_SHOW_OFF;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ST_SHOW_OFF: begin
        if (timer_q == GAP_LAST) begin
          timer_d = TIMER_ZERO;
          if (show_idx_q == last_idx) begin
            chk_idx_d = 4'd0;
            state_d   = ST_INPUT;
          end else begin
            show_idx_d = show_idx_q + 4'd1;
            state_d    = ST_SHOW_ON;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ST_INPUT: begin
        if (user_valid) begin
          if (user_digit != mem_rdata) begin
            state_d = ST_LOSE;
          end else if (chk_idx_q == last_idx) begin
            state_d = (level_q == MAX_LEVEL) ? ST_WIN : ST_GEN;
          end else begin
            chk_idx_d = chk_idx_q + 4'd1;
          end
        end else begin
          state_d = ST_INPUT;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start) begin
          state_d = ST_GEN;
          level_d = 5'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = 5'd0;
      end
    endcase
  end

  // Moore outputs derived from the upcoming state so they register in step with it.
  always_comb begin
    disp_on_d    = 1'b0;
    disp_digit_d = 4'd0;
    prompt_d     = (state_d == ST_INPUT);
    win_d        = (state_d == ST_WIN);
    lose_d       = (state_d == ST_LOSE);
    if (state_d == ST_SHOW_ON) begin
      disp_on_d = 1'b1;
      // A digit written this cycle is not yet visible on the read port.
      if (mem_we && (level_q[3:0] == mem_raddr)) begin
        disp_digit_d = random_num;
      end else begin
        disp_digit_d = mem_rdata;
      end
    end else begin
      disp_on_d = 1'b0;
    end
  end

  // Controller state, counters and timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      level_q    <= 5'd0;
      show_idx_q <= 4'd0;
      chk_idx_q  <= 4'd0;
      timer_q    <= TIMER_ZERO;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      show_idx_q <= show_idx_d;
      chk_idx_q  <= chk_idx_d;
      timer_q    <= timer_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_digit_q <= 4'd0;
      disp_on_q    <= 1'b0;
      prompt_q     <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      disp_digit_q <= disp_digit_d;
      disp_on_q    <= disp_on_d;
      prompt_q     <= prompt_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
    end
  end

  assign display_digit = disp_digit_q;
  assign display_on    = disp_on_q;
  assign prompt        = prompt_q;
  assign level         = level_q;
  assign win           = win_q;
  assign lose          = lose_q;

endmodule

// File: tb/tb_sequence_playback_checker.sv
// Directed bench for sequence_playback_checker with short show/gap timing.
module tb_sequence_playback_checker;

  logic       clk;
  logic       rst;
  logic [3:0] random_num;
  logic       enable;
  logic       start;
  logic       user_valid;
  logic [3:0] user_digit;
  logic [3:0] display_digit;
  logic       display_on;
  logic       prompt;
  logic [4:0] level;
  logic       win;
  logic       lose;

  int n_checks;
  int n_errors;

  sequence_playback_checker #(
    .SHOW_CYCLES (4),
    .GAP_CYCLES  (2),
    .MAX_LEN     (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .random_num    (random_num),
    .enable        (enable),
    .start         (start),
    .user_valid    (user_valid),
    .user_digit    (user_digit),
    .display_digit (display_digit),
    .display_on    (display_on),
    .prompt        (prompt),
    .level         (level),
    .win           (win),
    .lose          (lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    enable     = 1'b1;
    random_num = d;
    tick();
    enable     = 1'b0;
  endtask

  task automatic enter(input logic [3:0] d);
    user_valid = 1'b1;
    user_digit = d;
    tick();
    user_valid = 1'b0;
  endtask

  // Expect 4 clocks showing d then 2 blank clocks; optionally inject ignored strobes.
  task automatic expect_show(input logic [3:0] d, input logic [4:0] lvl, input bit noise);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        check_eq("show_on", {15'd0, display_on}, 16'd1);
        check_eq("show_digit", {12'd0, display_digit}, {12'd0, d});
      end else begin
        check_eq("gap_on", {15'd0, display_on}, 16'd0);
        check_eq("gap_digit", {12'd0, display_digit}, 16'd0);
      end
      check_eq("show_level", {11'd0, level}, {11'd0, lvl});
      check_eq("show_prompt", {15'd0, prompt}, 16'd0);
      enable     = noise;
      user_valid = noise;
      start      = noise;
      random_num = 4'hA;
      user_digit = 4'hF;
      tick();
      enable     = 1'b0;
      user_valid = 1'b0;
      start      = 1'b0;
    end
  endtask

  task automatic expect_prompt(input string tag, input logic [4:0] lvl);
    check_eq({tag, "_prompt"}, {15'd0, prompt}, 16'd1);
    check_eq({tag, "_level"}, {11'd0, level}, {11'd0, lvl});
  endtask

  task automatic expect_idle_outputs(input string tag);
    check_eq({tag, "_on"}, {15'd0, display_on}, 16'd0);
    check_eq({tag, "_digit"}, {12'd0, display_digit}, 16'd0);
    check_eq({tag, "_prompt"}, {15'd0, prompt}, 16'd0);
    check_eq({tag, "_level"}, {11'd0, level}, 16'd0);
    check_eq({tag, "_win"}, {15'd0, win}, 16'd0);
    check_eq({tag, "_lose"}, {15'd0, lose}, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    random_num = 4'd0;
    enable     = 1'b0;
    start      = 1'b0;
    user_valid = 1'b0;
    user_digit = 4'd0;
    tick();
    tick();
    expect_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // enable before start is ignored
    send_digit(4'd3);
    tick();
    expect_idle_outputs("idle_enable");

    // Game 1: 5, 9, 2 -> win
    pulse_start();
    expect_idle_outputs("gen0");
    send_digit(4'd5);
    expect_show(4'd5, 5'd1, 1'b0);
    expect_prompt("r1", 5'd1);
    enter(4'd5);
    check_eq("r1_done_prompt", {15'd0, prompt}, 16'd0);
    check_eq("r1_done_level", {11'd0, level}, 16'd1);
    send_digit(4'd9);
    expect_show(4'd5, 5'd2, 1'b0);
    expect_show(4'd9, 5'd2, 1'b0);
    expect_prompt("r2", 5'd2);
    enter(4'd5);
    check_eq("r2_mid_prompt", {15'd0, prompt}, 16'd1);
    enter(4'd9);
    send_digit(4'd2);
    expect_show(4'd5, 5'd3, 1'b0);
    expect_show(4'd9, 5'd3, 1'b0);
    expect_show(4'd2, 5'd3, 1'b0);
    expect_prompt("r3", 5'd3);
    enter(4'd5);
    enter(4'd9);
    enter(4'd2);
    check_eq("win_flag", {15'd0, win}, 16'd1);
    check_eq("win_level", {11'd0, level}, 16'd3);
    check_eq("win_prompt", {15'd0, prompt}, 16'd0);
    send_digit(4'd6);
    enter(4'd6);
    tick();
    check_eq("win_held", {15'd0, win}, 16'd1);
    check_eq("win_held_level", {11'd0, level}, 16'd3);
    pulse_start();
    check_eq("restart_win", {15'd0, win}, 16'd0);
    check_eq("restart_level", {11'd0, level}, 16'd0);

    // Game 2: 7, 4 with ignored strobes during playback, then a wrong entry
    send_digit(4'd7);
    expect_show(4'd7, 5'd1, 1'b1);
    expect_prompt("g2r1", 5'd1);
    enter(4'd7);
    send_digit(4'd4);
    expect_show(4'd7, 5'd2, 1'b1);
    expect_show(4'd4, 5'd2, 1'b1);
    expect_prompt("g2r2", 5'd2);
    enter(4'd7);
    enter(4'd3);
    check_eq("lose_flag", {15'd0, lose}, 16'd1);
    check_eq("lose_prompt", {15'd0, prompt}, 16'd0);
    check_eq("lose_win", {15'd0, win}, 16'd0);
    send_digit(4'd1);
    enter(4'd4);
    tick();
    check_eq("lose_held", {15'd0, lose}, 16'd1);
    check_eq("lose_level", {11'd0, level}, 16'd2);
    pulse_start();
    check_eq("restart_lose", {15'd0, lose}, 16'd0);
    check_eq("restart_lose_level", {11'd0, level}, 16'd0);

    // Reset mid-show
    send_digit(4'd6);
    tick();
    check_eq("pre_rst_on", {15'd0, display_on}, 16'd1);
    check_eq("pre_rst_digit", {12'd0, display_digit}, 16'd6);
    #2 rst = 1'b1;
    #1;
    expect_idle_outputs("async_rst");
    tick();
    rst = 1'b0;
    tick();
    send_digit(4'd8);
    tick();
    expect_idle_outputs("post_rst_enable");

    // Game after reset still works
    pulse_start();
    send_digit(4'd8);
    expect_show(4'd8, 5'd1, 1'b0);
    expect_prompt("post_rst", 5'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
